sn74ls444_arb: RTL



---
 rtl/sn74ls444_arb.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/sn74ls444_arb.sv
// Round-robin transfer arbiter for one 74LS444 transceiver: grants one of three
// requesters and sequences cs / s1,s0 / ga,gb,gc through setup, drive and turnaround.
module sn74ls444_arb #(
   parameter int HOLD = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] req,
   input  logic [2:0] dsta,
   input  logic [2:0] dstb,
   input  logic [2:0] dstc,
   output logic [2:0] ack,
   output logic [2:0] err,
   output logic       busy,
   output logic       cs,
   output logic       s1,
   output logic       s0,
   output logic       ga,
   output logic       gb,
   output logic       gc
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_DRIVE,
      ST_TURN
   } state_t;

   localparam logic [1:0] SRC_A    = 2'd0;
   localparam logic [1:0] SRC_B    = 2'd1;
   localparam logic [1:0] SRC_C    = 2'd2;
   localparam logic [1:0] SRC_IDLE = 2'd3;
   localparam logic [3:0] HOLD_LOAD = 4'(HOLD - 1);

   state_t     r_state;
   logic [1:0] r_src;
   logic [2:0] r_dmask;
   logic [3:0] r_cnt;
   logic [1:0] r_last;
   logic [2:0] r_ack;
   logic [2:0] r_err;
   logic       r_busy;
   logic       r_cs;
   logic [1:0] r_s;
   logic [2:0] r_g;

   state_t     w_state_nx;
   logic [1:0] w_src_nx;
   logic [2:0] w_dmask_nx;
   logic [3:0] w_cnt_nx;
   logic [1:0] w_last_nx;
   logic [2:0] w_ack_nx;
   logic [2:0] w_err_nx;
   logic       w_busy_nx;
   logic       w_cs_nx;
   logic [1:0] w_s_nx;
   logic [2:0] w_g_nx;

   logic [2:0] w_elig;
   logic [2:0] w_valid;
   logic [3:0] w_ok_by_code;
   logic [1:0] w_ord0;
   logic [1:0] w_ord1;
   logic [1:0] w_ord2;
   logic       w_found;
   logic [1:0] w_win;
   logic [2:0] w_win_dst;

   // A requester whose ack/err is showing is finishing its handshake, not asking again.
   assign w_elig  = req & ~r_ack & ~r_err;
   assign w_valid = {(dsta != 3'b000) && !dsta[2],
                     (dstb != 3'b000) && !dstb[1],
                     (dstc != 3'b000) && !dstc[0]};
   assign w_ok_by_code = {1'b0, w_elig[0] & w_valid[0], w_elig[1] & w_valid[1],
                          w_elig[2] & w_valid[2]};

   // NOTE: every signal driven in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      w_ord0 = SRC_A;
      w_ord1 = SRC_B;
      w_ord2 = SRC_C;
      unique case (r_last)
         SRC_A:   begin w_ord0 = SRC_B; w_ord1 = SRC_C; w_ord2 = SRC_A; end
         SRC_B:   begin w_ord0 = SRC_C; w_ord1 = SRC_A; w_ord2 = SRC_B; end
         default: begin w_ord0 = SRC_A; w_ord1 = SRC_B; w_ord2 = SRC_C; end
      endcase

      w_found = 1'b1;
      w_win   = w_ord0;
      if (w_ok_by_code[w_ord0])      w_win = w_ord0;
      else if (w_ok_by_code[w_ord1]) w_win = w_ord1;
      else if (w_ok_by_code[w_ord2]) w_win = w_ord2;
      else                           w_found = 1'b0;

      unique case (w_win)
         SRC_A:   w_win_dst = dsta;
         SRC_B:   w_win_dst = dstb;
         default: w_win_dst = dstc;
      endcase
   end

   always_comb begin
      w_state_nx = r_state;
      w_src_nx   = r_src;
      w_dmask_nx = r_dmask;
      w_cnt_nx   = r_cnt;
      w_last_nx  = r_last;
      w_err_nx   = 3'b000;

      unique case (r_state)
         ST_IDLE: begin
            w_err_nx = w_elig & ~w_valid;
            if (w_found) begin
               w_state_nx = ST_SETUP;
               w_src_nx   = w_win;
               w_dmask_nx = w_win_dst;
               w_last_nx  = w_win;
            end
         end
         ST_SETUP: begin
            w_cnt_nx   = HOLD_LOAD;
            w_state_nx = ST_DRIVE;
         end
         ST_DRIVE: begin
            if (r_cnt == 4'd0) w_state_nx = ST_TURN;
            else               w_cnt_nx   = r_cnt - 4'd1;
         end
         ST_TURN:  w_state_nx = ST_IDLE;
         default:  w_state_nx = ST_IDLE;
      endcase

      // Pin values are decoded from the state being entered so every output is a flop.
      w_cs_nx   = 1'b1;
      w_s_nx    = SRC_IDLE;
      w_g_nx    = 3'b111;
      w_busy_nx = 1'b0;
      w_ack_nx  = 3'b000;
      unique case (w_state_nx)
         ST_SETUP: begin
            w_cs_nx = 1'b0; w_s_nx = w_src_nx; w_busy_nx = 1'b1;
         end
         ST_DRIVE: begin
            w_cs_nx = 1'b0; w_s_nx = w_src_nx; w_busy_nx = 1'b1; w_g_nx = ~w_dmask_nx;
         end
         ST_TURN: begin
            w_cs_nx = 1'b0; w_s_nx = w_src_nx; w_busy_nx = 1'b1; w_ack_nx = 3'b100 >> w_src_nx;
         end
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_src   <= SRC_IDLE;
         r_dmask <= 3'b000;
         r_cnt   <= 4'd0;
         r_last  <= SRC_C;
         r_ack   <= 3'b000;
         r_err   <= 3'b000;
         r_busy  <= 1'b0;
         r_cs    <= 1'b1;
         r_s     <= SRC_IDLE;
         r_g     <= 3'b111;
      end else begin
         r_state <= w_state_nx;
         r_src   <= w_src_nx;
         r_dmask <= w_dmask_nx;
         r_cnt   <= w_cnt_nx;
         r_last  <= w_last_nx;
         r_ack   <= w_ack_nx;
         r_err   <= w_err_nx;
         r_busy  <= w_busy_nx;
         r_cs    <= w_cs_nx;
         r_s     <= w_s_nx;
         r_g     <= w_g_nx;
      end
   end

   assign ack  = r_ack;
   assign err  = r_err;
   assign busy = r_busy;
   assign cs   = r_cs;
   assign s1   = r_s[1];
   assign s0   = r_s[0];
   assign ga   = r_g[2];
   assign gb   = r_g[1];
   assign gc   = r_g[0];

endmodule
